// File: rtl/line_prefetch_if.sv
// SDRAM read port and OCM port-B write port used by the scanline prefetcher.
// master: prefetcher (drives reads and OCM writes); slave: controller/memory side.
interface line_prefetch_if;
   logic [24:0] sdram_addr;
   logic        sdram_read_n;
   logic        sdram_waitrequest;
   logic [15:0] sdram_readdata;
   logic        sdram_readdatavalid;
   logic [15:0] ocm_addr;
   logic [15:0] ocm_data;
   logic        ocm_we;

   modport master (
      output sdram_addr, sdram_read_n,
      input  sdram_waitrequest, sdram_readdata, sdram_readdatavalid,
      output ocm_addr, ocm_data, ocm_we
   );

   modport slave (
      input  sdram_addr, sdram_read_n,
      output sdram_waitrequest, sdram_readdata, sdram_readdatavalid,
      input  ocm_addr, ocm_data, ocm_we
   );
endinterface

// File: rtl/line_prefetch.sv
// Scanline prefetcher: streams one framebuffer line from SDRAM into a
// ping-pong OCM line buffer, keeping up to MAX_OUT reads in flight.
// Ports: MAIN_CLK, RESET (sync, active-high); line_start/line_num request;
// busy, done, overrun status; bus = SDRAM read + OCM write (master side).
module line_prefetch #(
   parameter logic [24:0] FB_BASE    = 25'h0,
   parameter int          LINE_WORDS = 640,
   parameter int          NUM_LINES  = 480,
   parameter int          MAX_OUT    = 4,
   parameter logic [15:0] OCM_BASE   = 16'h0000
) (
   input  logic       MAIN_CLK,
   input  logic       RESET,
   input  logic       line_start,
   input  logic [9:0] line_num,
   output logic       busy,
   output logic       done,
   output logic       overrun,
   line_prefetch_if.master bus
);

   localparam int CW = $clog2(LINE_WORDS + 1);
   localparam int OW = $clog2(MAX_OUT + 1);
   localparam logic [CW-1:0] LW   = CW'(LINE_WORDS);
   localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);
   localparam logic [OW-1:0] MO   = OW'(MAX_OUT);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t        state;
   state_t        state_nx;
   logic [24:0]   base;
   logic          bank;
   logic [CW-1:0] issue;
   logic [CW-1:0] recv;
   logic [OW-1:0] outst;
   logic          req;
   logic          start_ok;
   logic          accept;
   logic          rsp;
   logic          last_rsp;

   assign start_ok = line_start && (state == IDLE)
                     && (32'(line_num) < 32'(NUM_LINES));
   assign accept   = req && !bus.sdram_waitrequest;
   // responses arriving while idle belong to an abandoned line
   assign rsp      = bus.sdram_readdatavalid && (state != IDLE);
   assign last_rsp = rsp && (recv == LAST);

   always_ff @(posedge MAIN_CLK) begin
      if (RESET) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  if (start_ok) state_nx = FETCH;
         FETCH: begin
            if (last_rsp)
               state_nx = IDLE;
            else if (accept && issue == LAST)
               state_nx = DRAIN;
         end
         DRAIN: if (last_rsp) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // req depends only on registered state, so it holds under waitrequest
   always_comb begin
      busy = 1'b0;
      req  = 1'b0;
      unique case (state)
         FETCH: begin
            busy = 1'b1;
            req  = (issue < LW) && (outst < MO);
         end
         DRAIN:   busy = 1'b1;
         default: ;
      endcase
   end

   assign bus.sdram_read_n = ~req;
   assign bus.sdram_addr   = base + 25'(issue);

   always_ff @(posedge MAIN_CLK) begin
      if (RESET) begin
         overrun      <= 1'b0;
         done         <= 1'b0;
         bank         <= 1'b0;
         base         <= '0;
         issue        <= '0;
         recv         <= '0;
         outst        <= '0;
         bus.ocm_we   <= 1'b0;
         bus.ocm_addr <= '0;
         bus.ocm_data <= '0;
      end else begin
         if (line_start && busy) overrun <= 1'b1;
         if (start_ok) begin
            bank  <= line_num[0];
            base  <= FB_BASE + 25'(line_num) * 25'(LINE_WORDS);
            issue <= '0;
            recv  <= '0;
            outst <= '0;
         end else begin
            if (accept) issue <= issue + CW'(1);
            if (rsp)    recv  <= recv + CW'(1);
            unique case ({accept, rsp})
               2'b10:   outst <= outst + OW'(1);
               2'b01:   outst <= outst - OW'(1);
               default: ;
            endcase
         end
         bus.ocm_we <= rsp;
         done       <= last_rsp;
         if (rsp) begin
            bus.ocm_data <= bus.sdram_readdata;
            bus.ocm_addr <= OCM_BASE + {5'b0, bank, 10'b0} + 16'(recv);
         end
      end
   end

endmodule

// File: doc/line_prefetch.md
LINE_PREFETCH -- requirements
Module: line_prefetch

Interface
REQ-001 SHALL have parameter FB_BASE, default 25'h0, SDRAM word address of pixel (0,0).
REQ-002 SHALL have parameter LINE_WORDS, default 640, 16-bit pixel words per scanline.
REQ-003 SHALL have parameter NUM_LINES, default 480, number of valid scanlines.
REQ-004 SHALL have parameter MAX_OUT, default 4, maximum SDRAM reads in flight.
REQ-005 SHALL have parameter OCM_BASE, default 16'h0000, OCM port-B base address of the ping-pong line buffer.
REQ-006 SHALL have port MAIN_CLK  in  1  clock for all logic.
REQ-007 SHALL have port RESET  in  1  synchronous, active-high reset.
REQ-008 SHALL have port line_start  in  1  single-cycle request to fetch one line.
REQ-009 SHALL have port line_num  in  10  scanline to fetch; sampled when line_start is high.
REQ-010 SHALL have port busy  out  1  high from accepted request until its last OCM write.
REQ-011 SHALL have port done  out  1  one-cycle pulse with the last OCM write of a line.
REQ-012 SHALL have port overrun  out  1  sticky; set when line_start arrives while busy.
REQ-013 SHALL have port sdram_addr  out  25  read word address.
REQ-014 SHALL have port sdram_read_n  out  1  active-low read request.
REQ-015 SHALL have port sdram_waitrequest  in  1  controller stall; request is accepted when sdram_read_n=0 and sdram_waitrequest=0.
REQ-016 SHALL have port sdram_readdata  in  16  returned read data.
REQ-017 SHALL have port sdram_readdatavalid  in  1  sdram_readdata is valid this cycle; responses return in request order.
REQ-018 SHALL have port ocm_addr  out  16  OCM port-B address.
REQ-019 SHALL have port ocm_data  out  16  OCM port-B write data.
REQ-020 SHALL have port ocm_we  out  1  OCM port-B write enable, active high.

Function
REQ-021 SHALL implement states IDLE, FETCH and DRAIN.
REQ-022 IDLE -> FETCH when line_start=1 and line_num<NUM_LINES: latch bank=line_num[0], compute base=FB_BASE+line_num*LINE_WORDS mod 2^25, clear issue, receive and outstanding counters.
REQ-023 In IDLE, a line_start with line_num>=NUM_LINES SHALL be ignored: no state change, no done, no overrun.
REQ-024 In FETCH, sdram_read_n SHALL be 0 exactly when issue count<LINE_WORDS and outstanding<MAX_OUT, with sdram_addr=base+issue count.
REQ-025 While sdram_waitrequest=1 with a request pending, sdram_read_n and sdram_addr SHALL hold unchanged.
REQ-026 Issue count SHALL increment on each accepted request; FETCH -> DRAIN when issue count reaches LINE_WORDS; sdram_read_n=1 in DRAIN and IDLE.
REQ-027 Outstanding SHALL increment on accept, decrement on readdatavalid, and stay unchanged when both occur in one cycle; it never exceeds MAX_OUT.
REQ-028 On readdatavalid in FETCH or DRAIN, the cycle after SHALL drive ocm_we=1, ocm_data=readdata, ocm_addr=OCM_BASE+bank*1024+receive count; receive count then increments.
REQ-029 readdatavalid in IDLE SHALL be ignored, with no OCM write.
REQ-030 When the write of receive index LINE_WORDS-1 is driven, done SHALL be 1 for that cycle and the state SHALL return to IDLE.
REQ-031 busy SHALL be 1 in FETCH and DRAIN, 0 in IDLE.
REQ-032 line_start while busy SHALL be ignored and SHALL set overrun, which stays set until RESET.
REQ-033 Throughput SHALL be one word per cycle when waitrequest=0 and the controller returns data within MAX_OUT cycles.

Reset
REQ-034 While RESET=1 the block SHALL be in IDLE with busy=0, done=0, overrun=0, sdram_read_n=1, sdram_addr=0, ocm_we=0, ocm_addr=0, ocm_data=0, and all counters 0.
REQ-035 RESET mid-line SHALL abandon the line with no done, and SHALL drop late responses per REQ-029.

Verification
REQ-036 line_num=3, zero-wait controller with 2-cycle latency, LINE_WORDS=640 -> reads at 1920..2559 in order; OCM writes at 1024..1663 with matching data; one done pulse; busy low afterwards.
REQ-037 waitrequest held high 5 cycles on the 10th request -> sdram_addr and sdram_read_n stable for those cycles; no duplicate or skipped address.
REQ-038 controller latency 20 cycles, MAX_OUT=4 -> never more than 4 accepts ahead of responses; all 640 words written.
REQ-039 line_start during FETCH -> overrun=1, current line completes unaltered; line_num=480 in IDLE -> ignored, busy stays 0.
REQ-040 RESET asserted after 100 words, 2 responses still pending -> IDLE, no done, no OCM writes from the stale responses; the next line_num=0 fetches 0..639 into OCM 0..639.
